// File: rtl/mc_pkg.sv
// Shared opcodes, FSM states, select encodings and the control-word layout for multicycle_controller.
// MD_WAIT exists only when MULDIV_EN is defined.
package mc_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;
    localparam logic [6:0] OP_AUIPC  = 7'b0010111;

    typedef enum logic [4:0] {
        FETCH,
        DECODE,
        EXEC_R,
        EXEC_I,
        ALU_WB,
        MEM_ADR,
        MEM_RD,
        MEM_WB,
        MEM_WR,
        BRANCH,
        JAL,
        JALR1,
        JALR2,
        LUI,
        AUIPC,
`ifdef MULDIV_EN
        MD_WAIT,
`endif
        TRAP
    } state_t;

    // result_src encodings
    localparam logic [2:0] RES_ALUOUT = 3'd0;
    localparam logic [2:0] RES_ALU    = 3'd1;
    localparam logic [2:0] RES_MEM    = 3'd2;
    localparam logic [2:0] RES_IMM    = 3'd3;
    localparam logic [2:0] RES_LINK   = 3'd4;
    localparam logic [2:0] RES_MULDIV = 3'd5;

    // imm_src encodings
    localparam logic [2:0] IMM_I = 3'b000;
    localparam logic [2:0] IMM_S = 3'b001;
    localparam logic [2:0] IMM_B = 3'b010;
    localparam logic [2:0] IMM_U = 3'b100;

    typedef struct packed {
        logic       pc_write;
        logic       old_pc_write;
        logic       ir_write;
        logic       reg_write;
        logic       mem_read;
        logic       mem_write;
        logic       adr_src;
        logic [1:0] alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] alu_op;
        logic [2:0] imm_src;
        logic [2:0] result_src;
        logic       busy;
        logic       trap;
    } ctrl_t;

endpackage

// File: rtl/branch_cond.sv
// Purpose: evaluates a conditional-branch funct3 against the ALU flags.
// Latency: combinational, zero cycles.
// Backpressure: none; pure function of its inputs.
module branch_cond (
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    input  logic       ltu,
    output logic       taken,
    output logic       illegal
);

    always_comb begin
        taken   = 1'b0;
        illegal = 1'b0;
        case (funct3)
            3'b000:  taken = zero;
            3'b001:  taken = ~zero;
            3'b100:  taken = neg;
            3'b101:  taken = ~neg;
            3'b110:  taken = ltu;
            3'b111:  taken = ~ltu;
            default: illegal = 1'b1;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Purpose: multicycle RV32 control FSM; MULDIV_EN adds the multiply/divide path (m_op, mul_start, mul_done, MD_WAIT).
// Latency: one state per cycle; outputs are combinational from state, opcode, funct3 and flags.
// Backpressure: FETCH/MEM_RD/MEM_WR stall on mem_ready, trapping after WAIT_MAX unanswered cycles.
module multicycle_controller
    import mc_pkg::*;
#(
    parameter int WAIT_MAX = 8,
    parameter int WCNT_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] opc,
    input  logic [2:0] funct3,
    input  logic       zero,
    input  logic       neg,
    input  logic       ltu,
    input  logic       mem_ready,
`ifdef MULDIV_EN
    input  logic       mul_done,
    input  logic       m_op,
`endif
    output logic       pc_write,
    output logic       old_pc_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_read,
    output logic       mem_write,
    output logic       adr_src,
    output logic [1:0] alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [2:0] imm_src,
    output logic [2:0] result_src,
`ifdef MULDIV_EN
    output logic       mul_start,
`endif
    output logic       busy,
    output logic       trap
);

    state_t              state_q, state_d;
    logic [WCNT_W-1:0]   cnt_q, cnt_d;
    logic                br_taken, br_illegal;
    logic                waiting, timeout;
    ctrl_t               ctl;
`ifdef MULDIV_EN
    logic                md_wb_q, md_wb_d;
`endif

    branch_cond u_branch_cond (
        .funct3  (funct3),
        .zero    (zero),
        .neg     (neg),
        .ltu     (ltu),
        .taken   (br_taken),
        .illegal (br_illegal)
    );

    assign waiting = (state_q == FETCH) || (state_q == MEM_RD) || (state_q == MEM_WR);
    assign timeout = (cnt_q == WCNT_W'(WAIT_MAX)) && !mem_ready;

    always_comb begin
        state_d = state_q;
        case (state_q)
            FETCH:   if (mem_ready) state_d = DECODE; else if (timeout) state_d = TRAP;
            DECODE: begin
                case (opc)
                    OP_R:              state_d = EXEC_R;
                    OP_I:              state_d = EXEC_I;
                    OP_LOAD, OP_STORE: state_d = MEM_ADR;
                    OP_BRANCH:         state_d = BRANCH;
                    OP_JAL:            state_d = JAL;
                    OP_JALR:           state_d = JALR1;
                    OP_LUI:            state_d = LUI;
                    OP_AUIPC:          state_d = AUIPC;
                    default:           state_d = TRAP;
                endcase
            end
`ifdef MULDIV_EN
            EXEC_R:  state_d = m_op ? MD_WAIT : ALU_WB;
            MD_WAIT: if (mul_done) state_d = ALU_WB;
`else
            EXEC_R:  state_d = ALU_WB;
`endif
            EXEC_I:  state_d = ALU_WB;
            ALU_WB:  state_d = FETCH;
            MEM_ADR: state_d = (opc == OP_STORE) ? MEM_WR : MEM_RD;
            MEM_RD:  if (mem_ready) state_d = MEM_WB; else if (timeout) state_d = TRAP;
            MEM_WB:  state_d = FETCH;
            MEM_WR:  if (mem_ready) state_d = FETCH; else if (timeout) state_d = TRAP;
            BRANCH:  state_d = br_illegal ? TRAP : FETCH;
            JAL:     state_d = FETCH;
            JALR1:   state_d = JALR2;
            JALR2:   state_d = FETCH;
            LUI:     state_d = FETCH;
            AUIPC:   state_d = FETCH;
            TRAP:    state_d = TRAP;
            default: state_d = TRAP;
        endcase
    end

    // Counter only runs while stalled in the same wait state; any transition restarts it.
    always_comb begin
        cnt_d = '0;
        if (waiting && !mem_ready && (state_d == state_q))
            cnt_d = cnt_q + 1'b1;
    end

`ifdef MULDIV_EN
    assign md_wb_d = (state_q == MD_WAIT) && mul_done;
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= FETCH;
            cnt_q   <= '0;
`ifdef MULDIV_EN
            md_wb_q <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
`ifdef MULDIV_EN
            md_wb_q <= md_wb_d;
`endif
        end
    end

    // While rst is low the outputs look like an idle FETCH, whatever state_q holds.
    always_comb begin
        ctl = '0;
        if (!rst) begin
            ctl.mem_read = 1'b1;
        end else begin
            ctl.busy = (state_q != FETCH);
            case (state_q)
                FETCH: begin
                    ctl.mem_read = 1'b1;
                    if (mem_ready) begin
                        ctl.ir_write     = 1'b1;
                        ctl.pc_write     = 1'b1;
                        ctl.old_pc_write = 1'b1;
                        ctl.alu_src_b    = 2'b10;
                        ctl.result_src   = RES_ALU;
                    end
                end
                DECODE: begin
                    ctl.alu_src_a = 2'b01;
                    ctl.alu_src_b = 2'b01;
                    ctl.imm_src   = IMM_B;
                end
                EXEC_R: begin
                    ctl.alu_src_a = 2'b10;
                    ctl.alu_op    = 2'b10;
                end
                EXEC_I: begin
                    ctl.imm_src   = IMM_I;
                    ctl.alu_src_b = 2'b01;
                    ctl.alu_op    = 2'b10;
                end
                ALU_WB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.result_src = RES_ALUOUT;
`ifdef MULDIV_EN
                    if (md_wb_q) ctl.result_src = RES_MULDIV;
`endif
                end
                MEM_ADR: ctl.imm_src = (opc == OP_STORE) ? IMM_S : IMM_I;
                MEM_RD: begin
                    ctl.adr_src  = 1'b1;
                    ctl.mem_read = 1'b1;
                end
                MEM_WB: begin
                    ctl.reg_write  = 1'b1;
                    ctl.result_src = RES_MEM;
                end
                MEM_WR: begin
                    ctl.adr_src   = 1'b1;
                    ctl.mem_write = 1'b1;
                end
                BRANCH: begin
                    ctl.alu_op   = 2'b01;
                    ctl.pc_write = br_taken && !br_illegal;
                end
                JAL: begin
                    ctl.reg_write  = 1'b1;
                    ctl.result_src = RES_LINK;
                    ctl.pc_write   = 1'b1;
                end
                JALR1: begin
                    ctl.reg_write  = 1'b1;
                    ctl.result_src = RES_LINK;
                    ctl.alu_src_a  = 2'b10;
                    ctl.alu_src_b  = 2'b01;
                    ctl.imm_src    = IMM_I;
                end
                JALR2: begin
                    ctl.pc_write   = 1'b1;
                    ctl.result_src = RES_ALUOUT;
                end
                LUI: begin
                    ctl.reg_write  = 1'b1;
                    ctl.imm_src    = IMM_U;
                    ctl.result_src = RES_IMM;
                end
                AUIPC: begin
                    ctl.reg_write  = 1'b1;
                    ctl.alu_src_a  = 2'b01;
                    ctl.alu_src_b  = 2'b01;
                    ctl.imm_src    = IMM_U;
                    ctl.result_src = RES_ALUOUT;
                end
                TRAP:    ctl.trap = 1'b1;
                default: ;
            endcase
        end
    end

`ifdef MULDIV_EN
    assign mul_start = rst && (state_q == EXEC_R) && m_op;
`endif

    assign pc_write     = ctl.pc_write;
    assign old_pc_write = ctl.old_pc_write;
    assign ir_write     = ctl.ir_write;
    assign reg_write    = ctl.reg_write;
    assign mem_read     = ctl.mem_read;
    assign mem_write    = ctl.mem_write;
    assign adr_src      = ctl.adr_src;
    assign alu_src_a    = ctl.alu_src_a;
    assign alu_src_b    = ctl.alu_src_b;
    assign alu_op       = ctl.alu_op;
    assign imm_src      = ctl.imm_src;
    assign result_src   = ctl.result_src;
    assign busy         = ctl.busy;
    assign trap         = ctl.trap;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: each instruction is expanded into its expected per-cycle control words and
// checked at every negedge, with literal cycle/pulse counts pinning the expansion.
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst, zero, neg, ltu, mem_ready;
    logic [6:0] opc;
    logic [2:0] funct3;
    logic       pc_write, old_pc_write, ir_write, reg_write, mem_read, mem_write, adr_src;
    logic [1:0] alu_src_a, alu_src_b, alu_op;
    logic [2:0] imm_src, result_src;
    logic       busy, trap;

    always #5 clk = ~clk;

    multicycle_controller #(.WAIT_MAX(8), .WCNT_W(4)) dut (
        .clk(clk), .rst(rst), .opc(opc), .funct3(funct3),
        .zero(zero), .neg(neg), .ltu(ltu), .mem_ready(mem_ready),
        .pc_write(pc_write), .old_pc_write(old_pc_write), .ir_write(ir_write),
        .reg_write(reg_write), .mem_read(mem_read), .mem_write(mem_write),
        .adr_src(adr_src), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
        .alu_op(alu_op), .imm_src(imm_src), .result_src(result_src),
        .busy(busy), .trap(trap)
    );

    typedef struct packed {
        logic       pcw, opcw, irw, regw, mrd, mwr, adr;
        logic [1:0] a, b, op;
        logic [2:0] imm, res;
        logic       busy, trap;
    } obs_t;

    obs_t obs;
    always_comb begin
        obs = '{pcw: pc_write, opcw: old_pc_write, irw: ir_write, regw: reg_write,
                mrd: mem_read, mwr: mem_write, adr: adr_src, a: alu_src_a, b: alu_src_b,
                op: alu_op, imm: imm_src, res: result_src, busy: busy, trap: trap};
    end

    obs_t  exp_q[$];
    string name_q[$];
    string lit_name[$];
    int    lit_act[$];
    int    lit_exp[$];
    int    tests = 0, fails = 0;
    int    n_cyc = 0, n_regw = 0, n_memrd = 0, n_idle = 0, n_trap = 0, n_pcw = 0;

    // Single checker: every queued cycle expectation and every literal count is compared here.
    initial begin
        obs_t  e;
        string nm;
        int    a, x;
        forever begin
            @(negedge clk);
            n_cyc++;
            if (reg_write) n_regw++;
            if (mem_read && adr_src) n_memrd++;
            if (!busy) n_idle++;
            if (trap) n_trap++;
            if (pc_write) n_pcw++;
            if (exp_q.size() > 0) begin
                e  = exp_q.pop_front();
                nm = name_q.pop_front();
                tests++;
                if (obs !== e) begin
                    fails++;
                    $display("FAIL %s: got %h want %h", nm, obs, e);
                end
            end
            while (lit_name.size() > 0) begin
                nm = lit_name.pop_front();
                a  = lit_act.pop_front();
                x  = lit_exp.pop_front();
                tests++;
                if (a != x) begin
                    fails++;
                    $display("FAIL %s: got %0d want %0d", nm, a, x);
                end
            end
        end
    end

    function automatic obs_t e_idle();
        obs_t o = '0;
        o.busy = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_reset();
        obs_t o = '0;
        o.mrd = 1'b1;
        return o;
    endfunction

    function automatic obs_t e_fetch(input logic rdy);
        obs_t o = '0;
        o.mrd = 1'b1;
        if (rdy) begin
            o.irw = 1'b1; o.pcw = 1'b1; o.opcw = 1'b1; o.b = 2'b10; o.res = 3'd1;
        end
        return o;
    endfunction

    function automatic obs_t e_state(input int k, input logic flag);
        obs_t o = e_idle();
        case (k)
            0:  begin o.a = 2'b01; o.b = 2'b01; o.imm = 3'b010; end       // decode
            1:  begin o.op = 2'b10; o.a = 2'b10; end                      // R exec
            2:  begin o.imm = 3'b000; o.b = 2'b01; o.op = 2'b10; end      // I exec
            3:  begin o.regw = 1'b1; end                                  // ALU writeback
            4:  begin o.imm = flag ? 3'b001 : 3'b000; end                 // address calc
            5:  begin o.adr = 1'b1; o.mrd = 1'b1; end                     // load access
            6:  begin o.regw = 1'b1; o.res = 3'd2; end                    // load writeback
            7:  begin o.adr = 1'b1; o.mwr = 1'b1; end                     // store access
            8:  begin o.op = 2'b01; o.pcw = flag; end                     // branch
            9:  begin o.regw = 1'b1; o.res = 3'd4; o.pcw = 1'b1; end      // jal
            10: begin o.regw = 1'b1; o.res = 3'd4; o.a = 2'b10; o.b = 2'b01; end
            11: begin o.pcw = 1'b1; end                                   // jalr second
            12: begin o.regw = 1'b1; o.imm = 3'b100; o.res = 3'd3; end    // lui
            13: begin o.regw = 1'b1; o.a = 2'b01; o.b = 2'b01; o.imm = 3'b100; end
            default: begin o.trap = 1'b1; end                             // trap
        endcase
        return o;
    endfunction

    task automatic cyc(input logic rdy, input obs_t e, input string nm);
        mem_ready = rdy;
        exp_q.push_back(e);
        name_q.push_back(nm);
        @(posedge clk);
        #1;
    endtask

    task automatic lit(input string nm, input int act, input int x);
        lit_name.push_back(nm);
        lit_act.push_back(act);
        lit_exp.push_back(x);
    endtask

    task automatic fetch(input int dly, input string nm);
        for (int i = 0; i < dly; i++) cyc(1'b0, e_fetch(1'b0), {nm, "_fetch_wait"});
        cyc(1'b1, e_fetch(1'b1), {nm, "_fetch"});
        cyc(1'b0, e_state(0, 1'b0), {nm, "_decode"});
    endtask

    task automatic set_instr(input logic [6:0] o, input logic [2:0] f, input logic z, input logic n, input logic l);
        opc = o; funct3 = f; zero = z; neg = n; ltu = l;
    endtask

    task automatic do_reset(input int n, input string nm);
        rst = 1'b0;
        for (int i = 0; i < n; i++) cyc(1'b0, e_reset(), nm);
        rst = 1'b1;
    endtask

    task automatic branch(input logic [2:0] f, input logic z, input logic n, input logic l,
                          input logic tk, input string nm);
        set_instr(7'b1100011, f, z, n, l);
        fetch(0, nm);
        cyc(1'b0, e_state(8, tk), nm);
    endtask

    initial begin
        int s0, s1;
        rst = 1'b0; mem_ready = 1'b0;
        set_instr(7'b0, 3'b0, 1'b0, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        do_reset(2, "reset");

        // add, memory always ready
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        s0 = n_regw; s1 = n_cyc;
        fetch(0, "add");
        cyc(1'b1, e_state(1, 1'b0), "add_exec");
        cyc(1'b1, e_state(3, 1'b0), "add_wb");
        lit("add_regw_pulses", n_regw - s0, 1);
        lit("add_cycles", n_cyc - s1, 4);

        set_instr(7'b0010011, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(1, "addi");
        cyc(1'b0, e_state(2, 1'b0), "addi_exec");
        cyc(1'b0, e_state(3, 1'b0), "addi_wb");

        // lw with a 3-cycle memory stall
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        fetch(0, "lw");
        cyc(1'b0, e_state(4, 1'b0), "lw_adr");
        s0 = n_memrd;
        for (int i = 0; i < 3; i++) cyc(1'b0, e_state(5, 1'b0), "lw_rd_wait");
        cyc(1'b1, e_state(5, 1'b0), "lw_rd");
        lit("lw_mem_read_cycles", n_memrd - s0, 4);
        cyc(1'b0, e_state(6, 1'b0), "lw_wb");

        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        fetch(0, "sw");
        cyc(1'b0, e_state(4, 1'b1), "sw_adr");
        cyc(1'b0, e_state(7, 1'b0), "sw_wr_wait");
        cyc(1'b1, e_state(7, 1'b0), "sw_wr");

        s0 = n_pcw;
        branch(3'b110, 1'b0, 1'b0, 1'b1, 1'b1, "bltu_taken");
        branch(3'b110, 1'b0, 1'b0, 1'b0, 1'b0, "bltu_not");
        lit("bltu_pair_pc_writes", n_pcw - s0, 3);
        branch(3'b000, 1'b1, 1'b0, 1'b0, 1'b1, "beq_taken");
        branch(3'b001, 1'b1, 1'b0, 1'b0, 1'b0, "bne_not");
        branch(3'b100, 1'b0, 1'b1, 1'b0, 1'b1, "blt_taken");
        branch(3'b101, 1'b0, 1'b1, 1'b0, 1'b0, "bge_not");
        branch(3'b111, 1'b0, 1'b0, 1'b0, 1'b1, "bgeu_taken");

        set_instr(7'b1101111, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "jal");
        cyc(1'b0, e_state(9, 1'b0), "jal");
        set_instr(7'b1100111, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "jalr");
        cyc(1'b0, e_state(10, 1'b0), "jalr1");
        cyc(1'b0, e_state(11, 1'b0), "jalr2");
        set_instr(7'b0110111, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "lui");
        cyc(1'b0, e_state(12, 1'b0), "lui");
        set_instr(7'b0010111, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "auipc");
        cyc(1'b0, e_state(13, 1'b0), "auipc");

        // illegal branch funct3 traps after the BRANCH cycle
        branch(3'b010, 1'b1, 1'b1, 1'b1, 1'b0, "br_f3_010");
        for (int i = 0; i < 3; i++) cyc(1'b1, e_state(99, 1'b0), "br_f3_010_trap");
        do_reset(1, "br_trap_reset");

        // illegal opcode: trap held 20 cycles, one reset cycle clears it
        set_instr(7'b0000000, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "illegal_op");
        s0 = n_trap;
        for (int i = 0; i < 20; i++) cyc(i[0], e_state(99, 1'b0), "illegal_op_trap");
        lit("illegal_op_trap_cycles", n_trap - s0, 20);
        do_reset(1, "trap_reset");

        // fetch never answered: trap follows the 9th FETCH cycle
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        s0 = n_idle;
        for (int i = 0; i < 9; i++) cyc(1'b0, e_fetch(1'b0), "fetch_timeout_wait");
        lit("fetch_timeout_cycles", n_idle - s0, 9);
        cyc(1'b0, e_state(99, 1'b0), "fetch_timeout_trap");
        cyc(1'b1, e_state(99, 1'b0), "fetch_timeout_trap_hold");
        do_reset(1, "fetch_timeout_reset");

        // load never answered
        set_instr(7'b0000011, 3'b010, 1'b0, 1'b0, 1'b0);
        fetch(0, "lw_timeout");
        cyc(1'b0, e_state(4, 1'b0), "lw_timeout_adr");
        for (int i = 0; i < 9; i++) cyc(1'b0, e_state(5, 1'b0), "lw_timeout_wait");
        cyc(1'b0, e_state(99, 1'b0), "lw_timeout_trap");
        do_reset(1, "lw_timeout_reset");

        // reset mid-store, even with mem_ready high, kills mem_write and restarts at FETCH
        set_instr(7'b0100011, 3'b010, 1'b0, 1'b0, 1'b0);
        fetch(0, "sw_rst");
        cyc(1'b0, e_state(4, 1'b1), "sw_rst_adr");
        cyc(1'b0, e_state(7, 1'b0), "sw_rst_wr");
        rst = 1'b0;
        cyc(1'b1, e_reset(), "sw_rst_in_memwr");
        rst = 1'b1;
        set_instr(7'b0110011, 3'b000, 1'b0, 1'b0, 1'b0);
        fetch(0, "after_rst");
        cyc(1'b0, e_state(1, 1'b0), "after_rst_exec");
        cyc(1'b0, e_state(3, 1'b0), "after_rst_wb");

        repeat (3) @(posedge clk);
        #1;
        if (exp_q.size() != 0 || lit_name.size() != 0) begin
            $display("FAIL drain: %0d expectations left unchecked", exp_q.size() + lit_name.size());
            fails++;
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
